// File: rtl/reaction_round_ctrl.sv
// Multi-round reaction game sequencer: random target second, LED response window, hit/miss scoring.
// Optional macro REACTION_TIME_EN enables capture of the LED-on to press latency in react_cycles.
module reaction_round_ctrl #(
  parameter int unsigned ROUNDS      = 5,
  parameter int unsigned RESP_CYCLES = 12_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_pressed,
  input  logic [15:0] rnd,
  output logic        led_ext,
  output logic        busy,
  output logic [3:0]  round_idx,
  output logic [3:0]  score,
  output logic        hit,
  output logic        miss,
  output logic        done,
  output logic [23:0] react_cycles
);

  localparam logic [23:0] RESP_LAST  = 24'(RESP_CYCLES - 1);
  localparam logic [3:0]  ROUND_LAST = 4'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_COUNT,
    S_RESPOND,
    S_RESULT,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [3:0]  prev_target_q;
  logic [3:0]  target_q;
  logic [3:0]  sec_cnt_q;
  logic [23:0] resp_cnt_q;
  logic        won_q;
  logic        led_q;
  logic        busy_q;
  logic [3:0]  round_q;
  logic [3:0]  score_q;
  logic        hit_q;
  logic        miss_q;
  logic        done_q;

  logic [3:0]  t_raw;
  logic [3:0]  t_base;
  logic [3:0]  target_d;
  logic        unused_rnd_hi;

  assign unused_rnd_hi = ^rnd[15:4];

  // Map 0..15 onto 1..10, then bump away from the previous round's target.
  always_comb begin
    t_raw    = rnd[3:0];
    t_base   = (t_raw <= 4'd8) ? t_raw + 4'd1 : 4'd10;
    target_d = t_base;
    if (t_base == prev_target_q) begin
      target_d = (t_base == 4'd10) ? 4'd1 : t_base + 4'd1;
    end
  end

`ifdef REACTION_TIME_EN
  logic [23:0] react_q;
  assign react_cycles = react_q;
`else
  assign react_cycles = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      prev_target_q <= '0;
      target_q      <= '0;
      sec_cnt_q     <= '0;
      resp_cnt_q    <= '0;
      won_q         <= 1'b0;
      led_q         <= 1'b0;
      busy_q        <= 1'b0;
      round_q       <= '0;
      score_q       <= '0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef REACTION_TIME_EN
      react_q       <= '0;
`endif
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          led_q  <= 1'b0;
          busy_q <= 1'b0;
          if (btn_pressed) begin
            score_q <= '0;
            round_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ARM;
          end
        end
        S_ARM: begin
          target_q      <= target_d;
          prev_target_q <= target_d;
          sec_cnt_q     <= '0;
          state_q       <= S_COUNT;
        end
        S_COUNT: begin
          // An early press beats a coincident target tick.
          if (btn_pressed) begin
            won_q   <= 1'b0;
            state_q <= S_RESULT;
          end else if (tick) begin
            sec_cnt_q <= sec_cnt_q + 4'd1;
            if (sec_cnt_q + 4'd1 == target_q) begin
              led_q      <= 1'b1;
              resp_cnt_q <= '0;
              state_q    <= S_RESPOND;
            end
          end
        end
        S_RESPOND: begin
          resp_cnt_q <= resp_cnt_q + 24'd1;
          if (btn_pressed) begin
            won_q   <= 1'b1;
            score_q <= score_q + 4'd1;
            led_q   <= 1'b0;
            state_q <= S_RESULT;
`ifdef REACTION_TIME_EN
            react_q <= resp_cnt_q;
`endif
          end else if (resp_cnt_q == RESP_LAST) begin
            won_q   <= 1'b0;
            led_q   <= 1'b0;
            state_q <= S_RESULT;
          end
        end
        S_RESULT: begin
          hit_q  <= won_q;
          miss_q <= ~won_q;
          if (round_q == ROUND_LAST) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            round_q <= round_q + 4'd1;
            state_q <= S_ARM;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign led_ext   = led_q;
  assign busy      = busy_q;
  assign round_idx = round_q;
  assign score     = score_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed self-checking bench for reaction_round_ctrl with ROUNDS=3, RESP_CYCLES=8.
module tb_reaction_round_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        btn_pressed = 1'b0;
  logic [15:0] rnd = '0;
  logic        led_ext, busy, hit, miss, done;
  logic [3:0]  round_idx, score;
  logic [23:0] react_cycles;

  int nchk = 0;
  int nfail = 0;

`ifdef REACTION_TIME_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif

  reaction_round_ctrl #(.ROUNDS(3), .RESP_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_pressed(btn_pressed), .rnd(rnd),
    .led_ext(led_ext), .busy(busy), .round_idx(round_idx), .score(score),
    .hit(hit), .miss(miss), .done(done), .react_cycles(react_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock edge; single-cycle pulses are dropped afterwards and outputs are sampled 1 ns later.
  task automatic clk1();
    @(posedge clk);
    #1;
    tick = 1'b0;
    btn_pressed = 1'b0;
  endtask

  task automatic send_tick();
    repeat (19) clk1();
    tick = 1'b1;
    clk1();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clk1();
    clk1();
    nchk++; if (led_ext !== 1'b0) begin nfail++; $display("FAIL rst_led: got %0b want 0", led_ext); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_busy: got %0b want 0", busy); end
    nchk++; if ({hit, miss, done} !== 3'b000) begin nfail++; $display("FAIL rst_pulses: got %b want 000", {hit, miss, done}); end
    nchk++; if ({round_idx, score} !== 8'h00) begin nfail++; $display("FAIL rst_counts: got %h want 00", {round_idx, score}); end
    nchk++; if (react_cycles !== 24'd0) begin nfail++; $display("FAIL rst_react: got %0d want 0", react_cycles); end
    reset = 1'b0;
  endtask

  task automatic test_basic_hit();
    rnd = 16'h0003;
    btn_pressed = 1'b1;
    clk1();
    nchk++; if (busy !== 1'b1) begin nfail++; $display("FAIL start_busy: got %0b want 1", busy); end
    clk1();
    repeat (3) send_tick();
    nchk++; if (led_ext !== 1'b0) begin nfail++; $display("FAIL t4_led_early: got %0b want 0", led_ext); end
    send_tick();
    nchk++; if (led_ext !== 1'b1) begin nfail++; $display("FAIL t4_led_on: got %0b want 1", led_ext); end
    clk1();
    clk1();
    btn_pressed = 1'b1;
    clk1();
    nchk++; if (led_ext !== 1'b0) begin nfail++; $display("FAIL hit_led_off: got %0b want 0", led_ext); end
    nchk++; if (score !== 4'd1) begin nfail++; $display("FAIL hit_score: got %0d want 1", score); end
    nchk++; if (hit !== 1'b0) begin nfail++; $display("FAIL hit_latency: got %0b want 0", hit); end
    clk1();
    nchk++; if ({hit, miss} !== 2'b10) begin nfail++; $display("FAIL hit_pulse: got %b want 10", {hit, miss}); end
    nchk++; if (react_cycles !== (RT ? 24'd2 : 24'd0)) begin nfail++; $display("FAIL hit_react: got %0d want %0d", react_cycles, RT ? 2 : 0); end
    nchk++; if (round_idx !== 4'd1) begin nfail++; $display("FAIL round1: got %0d want 1", round_idx); end
  endtask

  task automatic test_timeout_miss();
    int n;
    clk1();
    repeat (4) send_tick();
    nchk++; if (led_ext !== 1'b0) begin nfail++; $display("FAIL rep_t5_early: got %0b want 0", led_ext); end
    send_tick();
    nchk++; if (led_ext !== 1'b1) begin nfail++; $display("FAIL rep_t5_on: got %0b want 1", led_ext); end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      clk1();
      if (led_ext === 1'b1) n++;
      else break;
    end
    nchk++; if (n !== 8) begin nfail++; $display("FAIL window_len: got %0d want 8", n); end
    nchk++; if (miss !== 1'b0) begin nfail++; $display("FAIL miss_latency: got %0b want 0", miss); end
    clk1();
    nchk++; if ({hit, miss} !== 2'b01) begin nfail++; $display("FAIL to_miss: got %b want 01", {hit, miss}); end
    nchk++; if (score !== 4'd1) begin nfail++; $display("FAIL to_score: got %0d want 1", score); end
    nchk++; if (round_idx !== 4'd2) begin nfail++; $display("FAIL round2: got %0d want 2", round_idx); end
    rnd = 16'h0003;
    clk1();
    nchk++; if (miss !== 1'b0) begin nfail++; $display("FAIL miss_one_cycle: got %0b want 0", miss); end
  endtask

  task automatic test_early_press();
    repeat (2) send_tick();
    repeat (3) clk1();
    btn_pressed = 1'b1;
    clk1();
    nchk++; if (led_ext !== 1'b0) begin nfail++; $display("FAIL early_led: got %0b want 0", led_ext); end
    clk1();
    nchk++; if ({miss, done, busy} !== 3'b111) begin nfail++; $display("FAIL early_end: got %b want 111", {miss, done, busy}); end
    clk1();
    nchk++; if ({done, busy} !== 2'b00) begin nfail++; $display("FAIL g1_idle: got %b want 00", {done, busy}); end
    nchk++; if ({round_idx, score} !== 8'h21) begin nfail++; $display("FAIL g1_hold: got %h want 21", {round_idx, score}); end
  endtask

  task automatic test_full_game();
    rnd = 16'h0002;
    btn_pressed = 1'b1;
    clk1();
    nchk++; if ({busy, round_idx, score} !== 9'h100) begin nfail++; $display("FAIL g2_start: got %h want 100", {busy, round_idx, score}); end
    clk1();
    repeat (2) send_tick();
    repeat (19) clk1();
    tick = 1'b1;
    btn_pressed = 1'b1;
    clk1();
    nchk++; if (led_ext !== 1'b0) begin nfail++; $display("FAIL coincide_led: got %0b want 0", led_ext); end
    clk1();
    nchk++; if ({hit, miss, round_idx} !== 6'b01_0001) begin nfail++; $display("FAIL coincide_miss: got %b want 010001", {hit, miss, round_idx}); end
    rnd = 16'h000F;
    clk1();
    repeat (9) send_tick();
    nchk++; if (led_ext !== 1'b0) begin nfail++; $display("FAIL t10_early: got %0b want 0", led_ext); end
    send_tick();
    nchk++; if (led_ext !== 1'b1) begin nfail++; $display("FAIL t10_on: got %0b want 1", led_ext); end
    repeat (7) clk1();
    nchk++; if (led_ext !== 1'b1) begin nfail++; $display("FAIL last_cycle_led: got %0b want 1", led_ext); end
    btn_pressed = 1'b1;
    clk1();
    nchk++; if ({led_ext, score} !== 5'h01) begin nfail++; $display("FAIL last_cycle_hit: got %h want 01", {led_ext, score}); end
    clk1();
    nchk++; if ({hit, round_idx} !== 5'h12) begin nfail++; $display("FAIL g2_hit2: got %h want 12", {hit, round_idx}); end
    nchk++; if (react_cycles !== (RT ? 24'd7 : 24'd0)) begin nfail++; $display("FAIL react_last: got %0d want %0d", react_cycles, RT ? 7 : 0); end
    rnd = 16'h0009;
    clk1();
    send_tick();
    nchk++; if (led_ext !== 1'b1) begin nfail++; $display("FAIL wrap_t1: got %0b want 1", led_ext); end
    btn_pressed = 1'b1;
    clk1();
    clk1();
    nchk++; if ({hit, done, busy, score} !== 7'b111_0010) begin nfail++; $display("FAIL g2_end: got %b want 1110010", {hit, done, busy, score}); end
    nchk++; if (react_cycles !== 24'd0) begin nfail++; $display("FAIL react_zero: got %0d want 0", react_cycles); end
    clk1();
    nchk++; if ({hit, done, busy} !== 3'b000) begin nfail++; $display("FAIL g2_idle: got %b want 000", {hit, done, busy}); end
    tick = 1'b1;
    clk1();
    repeat (3) clk1();
    nchk++; if ({busy, led_ext, round_idx, score} !== 10'b00_0010_0010) begin nfail++; $display("FAIL idle_tick: got %b want 0000100010", {busy, led_ext, round_idx, score}); end
  endtask

  task automatic test_reset_mid_respond();
    rnd = 16'h0000;
    btn_pressed = 1'b1;
    clk1();
    clk1();
    repeat (2) send_tick();
    nchk++; if (led_ext !== 1'b1) begin nfail++; $display("FAIL pre_rst_led: got %0b want 1", led_ext); end
    clk1();
    reset = 1'b1;
    clk1();
    reset = 1'b0;
    nchk++; if ({led_ext, busy, hit, miss, done, round_idx, score} !== 13'd0) begin nfail++; $display("FAIL mid_rst: got %b want 0", {led_ext, busy, hit, miss, done, round_idx, score}); end
    nchk++; if (react_cycles !== 24'd0) begin nfail++; $display("FAIL mid_rst_react: got %0d want 0", react_cycles); end
    btn_pressed = 1'b1;
    clk1();
    nchk++; if ({busy, score} !== 5'h10) begin nfail++; $display("FAIL restart: got %h want 10", {busy, score}); end
    clk1();
    send_tick();
    nchk++; if (led_ext !== 1'b1) begin nfail++; $display("FAIL prev_cleared: got %0b want 1", led_ext); end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_timeout_miss();
    test_early_press();
    test_full_game();
    test_reset_mid_respond();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/reaction_round_ctrl.md
Name: reaction_round_ctrl

Overview:
- Sequences a multi-round reaction game on top of the 1 Hz tick, debounced button-press pulse and 16-bit LFSR already present in the LED/PRNG design.
- Each round draws a random target second (1..10) and counts ticks until that second. It then lights the external LED and opens a response window. A button press inside the window scores a hit.
- Owns `led_ext` during a game. After ROUNDS rounds it reports the score and returns to idle.

Parameters:
- ROUNDS, 5: rounds per game; legal range 1..15.
- RESP_CYCLES, 12_500_000: response window length in clk cycles; legal range 2..2^24-1.

Ports:
- clk  in  1  system clock, 25 MHz.
- reset  in  1  reset; synchronous, active-high.
- tick  in  1  one-cycle 1 Hz strobe from the clock divider.
- btn_pressed  in  1  one-cycle rising-edge pulse of the debounced button.
- rnd  in  16  free-running LFSR value; only bits [3:0] are used.
- led_ext  out  1  target indicator LED.
- busy  out  1  high from game start until the DONE cycle, inclusive.
- round_idx  out  4  current round, 0-based.
- score  out  4  number of hits in the current or last game.
- hit  out  1  one-cycle pulse when a round is scored as a hit.
- miss  out  1  one-cycle pulse when a round is scored as a miss.
- done  out  1  one-cycle pulse at game end.
- react_cycles  out  24  reaction time of the last hit (see Optional Feature).

Behaviour:
- Reset values: state=IDLE; `led_ext`, `busy`, `hit`, `miss`, `done` = 0; `round_idx`, `score`, `react_cycles` = 0; internal `prev_target`=0; `sec_cnt`=0; `resp_cnt`=0. Reset has priority over every other input, including mid-game.
- All outputs are registered.
- Target mapping, computed in the ARM state:
  - t = rnd[3:0]; target = (t<=8) ? t+1 : 10.
  - If target == prev_target, then target = (target==10) ? 1 : target+1.
  - prev_target <= target. prev_target persists across games.
- IDLE:
  - `led_ext`=0, `busy`=0.
  - On `btn_pressed`: score<=0, round_idx<=0, busy<=1, go to ARM.
  - `tick` is ignored in IDLE.
- ARM (exactly 1 cycle):
  - Latch target; sec_cnt<=0; go to COUNT.
  - A `tick` or `btn_pressed` arriving in this cycle is ignored.
- COUNT:
  - On `tick`: sec_cnt<=sec_cnt+1. If sec_cnt+1 == target: led_ext<=1, resp_cnt<=0, go to RESPOND.
  - On `btn_pressed` (early press): go to RESULT with a miss.
  - If `tick` and `btn_pressed` coincide, the button wins: miss, LED stays 0.
- RESPOND:
  - `led_ext`=1; resp_cnt increments every cycle.
  - `btn_pressed` while resp_cnt <= RESP_CYCLES-1 is a hit: score<=score+1. A press on the last window cycle counts as a hit.
  - resp_cnt == RESP_CYCLES-1 with no press is a miss.
  - On exit, led_ext<=0 in the same edge that enters RESULT.
  - `tick` is ignored in RESPOND.
- RESULT (1 cycle):
  - Pulse `hit` or `miss`.
  - If round_idx == ROUNDS-1, go to DONE. Otherwise round_idx<=round_idx+1 and go to ARM.
- DONE (1 cycle):
  - done=1, busy stays 1 this cycle, then IDLE.
  - `score` and `round_idx` hold until the next game start.
- Latencies:
  - Start press to ARM: 1 cycle.
  - Target tick to `led_ext` high: 1 cycle.
  - Hit press to `hit` pulse: 2 cycles (RESPOND→RESULT edge, then pulse registered out of RESULT).
- `score` never exceeds ROUNDS; no wrap is possible.

Optional Feature:
- Macro: REACTION_TIME_EN.
- Defined: on each hit, react_cycles<=resp_cnt, the cycles from LED-on to press, 0-based. It holds until the next hit or reset and is not cleared at game start.
- Undefined: `react_cycles` is tied to 0 and no capture register is synthesised.

Test Plan:
All scenarios use ROUNDS=3, RESP_CYCLES=8, with `tick` driven every 20 cycles.
1. Basic hit: reset, rnd=16'h0003, press.
   - Required: target=4; `led_ext` rises 1 cycle after the 4th tick following ARM.
   - Press 3 cycles after LED-on: `hit` pulse, score=1, react_cycles=2 (with REACTION_TIME_EN) or 0 (without); LED low.
2. Timeout miss: target hit with no press.
   - Required: `led_ext` high for exactly 8 cycles, then a `miss` pulse; score unchanged.
3. Early press: press after the 2nd tick with target=4, and separately press coincident with the 4th tick.
   - Required: `miss` both times; `led_ext` never asserted.
4. Repeat avoidance: rnd[3:0]=3 for two consecutive rounds → targets 4 then 5. rnd[3:0]=9..15 twice → targets 10 then 1.
5. Full game: 3 rounds scoring hit, miss, hit.
   - Required: round_idx steps 0,1,2; `done` single pulse; score=2; busy drops the cycle after `done`; a `tick` in IDLE has no effect.
6. Reset mid-RESPOND, with `led_ext`=1.
   - Required: next cycle all outputs are at reset values, state=IDLE; a new press starts a game with score=0.
